// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// seg_pkg : shared constants for the seven-segment scan display
// Rev 1.0 : initial release
// ============================================================================
package seg_pkg;

  // Bit positions inside the 8-bit segment bus {p,g,f,e,d,c,b,a}
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_P = 7;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {g..a} glyphs for hex digits 0..F
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage
`default_nettype wire

// File: rtl/seg_hex_lut.sv
`default_nettype none
// ============================================================================
// seg_hex_lut : nibble to active-low seven-segment glyph
// Rev 1.0 : initial release
// ============================================================================
module seg_hex_lut
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = SEG_HEX[nibble];

endmodule
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// seg_scan_display : multiplexed N-digit common-anode seven-segment driver
// Rev 1.0 : initial release
// ============================================================================
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_TICKS = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     le,
  input  logic [DIGITS-1:0]     blink,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [IW-1:0] c_idx_last = IW'(DIGITS - 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] c_blk_last = BW'(BLINK_TICKS - 1);

  logic [4*DIGITS-1:0] r_data;
  logic [DIGITS-1:0]   r_point;
  logic [DIGITS-1:0]   r_le;
  logic [DIGITS-1:0]   r_blink;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [BW-1:0]       r_bcnt;
  logic                r_phase_off;
  logic [DIGITS-1:0]   r_an;
  logic [7:0]          r_seg;

  logic                w_tick;
  logic                w_frame;
  logic [3:0]          w_nibble;
  logic [6:0]          w_pattern;
  logic                w_visible;
  logic [7:0]          w_seg_next;
  logic [DIGITS-1:0]   w_an_next;

  assign w_tick  = (r_cnt == c_cnt_last);
  assign w_frame = w_tick && (r_idx == c_idx_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data  <= '0;
      r_point <= '0;
      r_le    <= '0;
      r_blink <= '0;
    end else if (load) begin
      r_data  <= data;
      r_point <= point;
      r_le    <= le;
      r_blink <= blink;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_bcnt      <= '0;
      r_phase_off <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end
      // Blink phase advances only at frame boundaries so every digit sees whole frames
      if (w_frame) begin
        if (r_bcnt == c_blk_last) begin
          r_bcnt      <= '0;
          r_phase_off <= ~r_phase_off;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end
    end
  end

  assign w_nibble  = r_data[{r_idx, 2'b00} +: 4];
  assign w_visible = r_le[r_idx] & ~(r_blink[r_idx] & r_phase_off);
  assign w_an_next = ~(DIGITS'(1) << r_idx);

  seg_hex_lut u_hex_lut (
    .nibble  (w_nibble),
    .pattern (w_pattern)
  );

  always_comb begin
    w_seg_next = SEG_OFF;
    if (w_visible) begin
      w_seg_next[SEG_G:SEG_A] = w_pattern;
      w_seg_next[SEG_P]       = ~r_point[r_idx];
    end
  end

  // Blanked digits keep their anode so the scan cadence never changes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_an  <= '1;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_done = w_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// ============================================================================
// tb_seg_scan_display : directed bench with a cycle-level reference model
// Rev 1.0 : initial release
// ============================================================================
module tb_seg_scan_display;

  localparam int D     = 4;
  localparam int SD    = 4;
  localparam int BT    = 2;
  localparam int FRAME = D * SD;

  logic          clk = 1'b0;
  logic          rstn;
  logic          load;
  logic [4*D-1:0] data;
  logic [D-1:0]  point;
  logic [D-1:0]  le;
  logic [D-1:0]  blink;
  logic [D-1:0]  an;
  logic [7:0]    seg;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_display #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .load       (load),
    .data       (data),
    .point      (point),
    .le         (le),
    .blink      (blink),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] hexlut [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Model state: edges since reset release, plus shadow contents now and one edge ago
  int             t = 0;
  logic [4*D-1:0] m_data = '0, m_data_p = '0;
  logic [D-1:0]   m_pt = '0, m_pt_p = '0;
  logic [D-1:0]   m_le = '0, m_le_p = '0;
  logic [D-1:0]   m_bl = '0, m_bl_p = '0;

  always @(posedge clk) begin
    if (!rstn) begin
      t = 0;
      m_data = '0; m_pt = '0; m_le = '0; m_bl = '0;
      m_data_p = '0; m_pt_p = '0; m_le_p = '0; m_bl_p = '0;
    end else begin
      m_data_p = m_data; m_pt_p = m_pt; m_le_p = m_le; m_bl_p = m_bl;
      if (load) begin
        m_data = data; m_pt = point; m_le = le; m_bl = blink;
      end
      t++;
    end
  end

  function automatic void model_out(output logic [D-1:0] e_an, output logic [7:0] e_seg,
                                    output logic e_fd);
    int tp, i, ph;
    logic vis;
    e_an  = '1;
    e_seg = 8'hFF;
    e_fd  = 1'b0;
    if (rstn && t > 0) begin
      tp    = t - 1;
      i     = (tp / SD) % D;
      ph    = (tp / (FRAME * BT)) % 2;
      e_an  = ~(D'(1) << i);
      vis   = m_le_p[i] && !(m_bl_p[i] && ph == 1);
      if (vis) e_seg = {~m_pt_p[i], hexlut[m_data_p[4*i +: 4]]};
    end
    if (rstn) e_fd = ((t % FRAME) == FRAME - 1);
  endfunction

  always @(negedge clk) begin
    logic [D-1:0] e_an;
    logic [7:0]   e_seg;
    logic         e_fd;
    model_out(e_an, e_seg, e_fd);
    checks += 3;
    if (an !== e_an) begin
      errors++;
      $display("FAIL model_an t=%0d got=%b want=%b", t, an, e_an);
    end
    if (seg !== e_seg) begin
      errors++;
      $display("FAIL model_seg t=%0d got=%h want=%h", t, seg, e_seg);
    end
    if (frame_done !== e_fd) begin
      errors++;
      $display("FAIL model_frame_done t=%0d got=%b want=%b", t, frame_done, e_fd);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_an(input logic [D-1:0] target);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== target && n < 64);
    if (an !== target) check("wait_an_timeout", 32'(an), 32'(target));
  endtask

  task automatic wait_phase(input int r);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((t % FRAME) != r && n < 64);
    if ((t % FRAME) != r) check("wait_phase_timeout", 32'(t % FRAME), 32'(r));
  endtask

  task automatic do_load(input logic [4*D-1:0] d, input logic [D-1:0] p,
                         input logic [D-1:0] e, input logic [D-1:0] b);
    @(negedge clk); #1;
    data = d; point = p; le = e; blink = b; load = 1'b1;
    @(negedge clk); #1;
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_cnt, lit_cnt, on_cnt, off_cnt;
    logic [7:0] dig_exp [D];
    dig_exp = '{8'hC0, 8'hB0, 8'h08, 8'h80};

    rstn = 1'b0; load = 1'b0; data = '0; point = '0; le = '0; blink = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'hFF);
    check("reset_frame_done", 32'(frame_done), 32'h0);

    rstn = 1'b1;
    check("release_an_before_edge", 32'(an), 32'hF);

    // Blank scan: two frames in 32 clocks, never a lit segment
    fd_cnt = 0; lit_cnt = 0;
    repeat (32) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (seg !== 8'hFF) lit_cnt++;
    end
    check("blank_frame_pulses", 32'(fd_cnt), 32'd2);
    check("blank_no_segments", 32'(lit_cnt), 32'd0);

    do_load(16'h8A30, 4'b0100, 4'hF, 4'h0);
    for (int k = 0; k < D; k++) begin
      wait_an(~(D'(1) << k));
      check($sformatf("digit%0d_seg", k), 32'(seg), 32'(dig_exp[k]));
    end

    // Load coinciding with the tick that moves idx 0 -> 1
    do_load(16'h0000, 4'h0, 4'hF, 4'h0);
    wait_phase(3);
    #1;
    data = 16'h00F0; load = 1'b1;
    @(negedge clk); #1;
    load = 1'b0;
    wait_an(4'b1101);
    check("tick_load_seg", 32'(seg), 32'h8E);

    do_load(16'h8A30, 4'b0100, 4'hF, 4'b0001);
    repeat (20) @(negedge clk);
    on_cnt = 0; off_cnt = 0;
    repeat (128) begin
      @(negedge clk);
      if (an === 4'b1110 && seg === 8'hC0) on_cnt++;
      if (an === 4'b1110 && seg === 8'hFF) off_cnt++;
    end
    check("blink_on_slots", 32'(on_cnt), 32'd16);
    check("blink_off_slots", 32'(off_cnt), 32'd16);
    wait_an(4'b1011);
    check("blink_other_digit", 32'(seg), 32'h08);

    // Asynchronous reset in the middle of digit 2's slot
    wait_phase(9);
    #1;
    rstn = 1'b0;
    #1;
    check("async_reset_an", 32'(an), 32'hF);
    check("async_reset_seg", 32'(seg), 32'hFF);
    check("async_reset_fd", 32'(frame_done), 32'h0);
    @(negedge clk); #1;
    rstn = 1'b1;
    wait_an(4'b1110);
    check("post_reset_first_digit_blank", 32'(seg), 32'hFF);
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
